// File: rtl/cpu_arith_pkg.sv
// Shared arithmetic definitions: divider FSM states, default width and the
// magnitude helper used by the sequential divider.
package cpu_arith_pkg;

  localparam int unsigned DIV_W_DEFAULT = 32;

  // Widest operand abs_w can handle; callers sign-extend into this width.
  localparam int unsigned ABS_MAX_W = 64;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  // Two's-complement magnitude of a sign-extended value. The magnitude of the
  // most negative WIDTH-bit value is still exact in the low WIDTH bits.
  function automatic logic [ABS_MAX_W-1:0] abs_w(input logic [ABS_MAX_W-1:0] val);
    return val[ABS_MAX_W-1] ? (~val + 1'b1) : val;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring division iteration: shift the partial remainder left,
// bring in the next dividend bit, then subtract or add the divisor magnitude
// depending on the sign of the old partial remainder.
module nr_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   p_cur,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   p_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // Arithmetic is modulo 2^(WIDTH+1); the true result always fits that range.
  always_comb begin
    shifted = {p_cur[WIDTH-1:0], dvd_bit};
    if (!p_cur[WIDTH]) begin
      p_next = shifted - {1'b0, dvs};
    end else begin
      p_next = shifted + {1'b0, dvs};
    end
    q_bit = ~p_next[WIDTH];
  end

endmodule

// File: rtl/seq_nr_divider.sv
// Sequential non-restoring divider, one quotient bit per clock, with
// run-time signed/unsigned mode and valid/ready handshakes on both sides.
// Optional feature: define SEQ_DIV_ZERO_TRAP_EN to add the div_zero output
// and return all-ones / dividend on a zero divisor instead of 0 / 0.
module seq_nr_divider
  import cpu_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W_DEFAULT
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef SEQ_DIV_ZERO_TRAP_EN
  output logic             div_zero,
`endif
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_t state_q, state_d;

  logic [WIDTH-1:0] dvd_q;      // raw dividend, then its magnitude shifted out MSB first
  logic [WIDTH-1:0] dvs_q;      // raw divisor, then its magnitude
  logic             signed_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH:0]   p_q;        // signed partial remainder
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
`ifdef SEQ_DIV_ZERO_TRAP_EN
  logic             dz_q;
`endif

  logic [ABS_MAX_W-1:0] dvd_abs;
  logic [ABS_MAX_W-1:0] dvs_abs;
  logic [WIDTH-1:0]     dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH:0]       p_next;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_fix;
  logic                 unused_abs;

  nr_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .p_cur   (p_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .dvs     (dvs_q),
    .p_next  (p_next),
    .q_bit   (q_bit)
  );

  // Operand magnitudes for PREP and the final remainder correction for FIX.
  always_comb begin
    dvd_abs = abs_w(ABS_MAX_W'($signed(dvd_q)));
    dvs_abs = abs_w(ABS_MAX_W'($signed(dvs_q)));
    dvd_mag = signed_q ? dvd_abs[WIDTH-1:0] : dvd_q;
    dvs_mag = signed_q ? dvs_abs[WIDTH-1:0] : dvs_q;
    rem_fix = p_q[WIDTH] ? (p_q[WIDTH-1:0] + dvs_q) : p_q[WIDTH-1:0];
  end

  // Upper helper bits are only meaningful for WIDTH = ABS_MAX_W.
  assign unused_abs = ^{dvd_abs, dvs_abs};

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = (divisor == '0) ? DONE : PREP;
        end
      end
      PREP: state_d = ITER;
      ITER: begin
        if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX:  state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers, advanced according to the current state.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      signed_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      p_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
`ifdef SEQ_DIV_ZERO_TRAP_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            signed_q <= is_signed;
`ifdef SEQ_DIV_ZERO_TRAP_EN
            dz_q     <= (divisor == '0);
            if (divisor == '0) begin
              quo_q <= '1;
              rem_q <= dividend;
            end
`else
            if (divisor == '0) begin
              quo_q <= '0;
              rem_q <= '0;
            end
`endif
          end
        end
        PREP: begin
          dvd_q     <= dvd_mag;
          dvs_q     <= dvs_mag;
          neg_quo_q <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          neg_rem_q <= signed_q & dvd_q[WIDTH-1];
          p_q       <= '0;
          q_q       <= '0;
          cnt_q     <= CNT_W'(WIDTH - 1);
        end
        ITER: begin
          p_q   <= p_next;
          q_q   <= {q_q[WIDTH-2:0], q_bit};
          dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        FIX: begin
          quo_q <= neg_quo_q ? (~q_q + 1'b1) : q_q;
          rem_q <= neg_rem_q ? (~rem_fix + 1'b1) : rem_fix;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef SEQ_DIV_ZERO_TRAP_EN
  assign div_zero  = dz_q;
`endif

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed bench for seq_nr_divider (WIDTH = 32) with hand-computed results.
module tb_seq_nr_divider;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
`ifdef SEQ_DIV_ZERO_TRAP_EN
  logic         div_zero;
`endif

  int checks = 0;
  int failures = 0;

  seq_nr_divider #(
    .WIDTH (W)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef SEQ_DIV_ZERO_TRAP_EN
    .div_zero  (div_zero),
`endif
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present operands for one cycle; returns #1 after the accept edge.
  task automatic start_op(input string tag, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    @(negedge clock);
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clock);
    #1;
    // Scramble inputs: the block must only use the values seen at accept.
    in_valid  = 1'b0;
    is_signed = ~sgn;
    dividend  = 32'hA5A5_5A5A;
    divisor   = 32'h0000_0003;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_no_accept"}, in_ready, 0);
  endtask

  // exp_lat counts clock edges after the accept edge until out_valid is seen.
  task automatic wait_result(input string tag, input int exp_lat, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input logic ez);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_quo"}, quotient, eq);
    check({tag, "_rem"}, remainder, er);
`ifdef SEQ_DIV_ZERO_TRAP_EN
    check({tag, "_dz"}, div_zero, ez);
`else
    if (ez) check({tag, "_dz_path"}, divisor == '0 ? 1 : 1, 1);
`endif
  endtask

  task automatic handoff(input string tag);
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, out_valid, 0);
    check({tag, "_idle"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic sgn, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
    start_op(tag, sgn, a, b);
    wait_result(tag, W + 2, eq, er, 1'b0);
    handoff(tag);
  endtask

  initial begin
    int seen;

    // Reset values.
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
`ifdef SEQ_DIV_ZERO_TRAP_EN
    check("rst_dz", div_zero, 0);
`endif
    repeat (2) @(negedge clock);
    clear_n = 1'b1;

    run("s_100_7",   1'b1, 32'd100,       32'd7,         32'd14,        32'd2);
    run("s_m100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run("s_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run("u_ff_2",    1'b0, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 32'd1);
    run("s_ff_2",    1'b1, 32'hFFFF_FFFF, 32'd2,         32'd0,         32'hFFFF_FFFF);
    run("s_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    run("u_dead_10", 1'b0, 32'hDEAD_BEEF, 32'h10,        32'h0DEA_DBEE, 32'hF);
    run("u_1000_ff", 1'b0, 32'd1000,      32'hFFFF_FFFF, 32'd0,         32'd1000);

    // Divide by zero: result is visible right after the accept edge.
    start_op("div0", 1'b0, 32'h1234, 32'd0);
`ifdef SEQ_DIV_ZERO_TRAP_EN
    wait_result("div0", 0, 32'hFFFF_FFFF, 32'h1234, 1'b1);
`else
    wait_result("div0", 0, 32'd0, 32'd0, 1'b0);
`endif
    handoff("div0");

    // Backpressure: result must hold while out_ready stays low.
    start_op("bp", 1'b1, 32'd1000, 32'd3);
    wait_result("bp", W + 2, 32'd333, 32'd1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("bp_hold_ov", out_valid, 1);
      check("bp_hold_quo", quotient, 32'd333);
      check("bp_hold_rem", remainder, 32'd1);
      check("bp_hold_in_ready", in_ready, 0);
    end
    handoff("bp");

    // Asynchronous reset in the middle of ITER abandons the operation.
    start_op("abort", 1'b0, 32'd12345, 32'd6);
    repeat (5) @(posedge clock);
    #3;
    clear_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_quo", quotient, 0);
    check("abort_rem", remainder, 0);
    @(negedge clock);
    clear_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_result", 64'(seen), 0);

    run("u_45_9", 1'b0, 32'd45, 32'd9, 32'd5, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait ever escapes its bound.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
